// File: rtl/dds_multichannel.sv
// -----------------------------------------------------------------------------
// dds_multichannel
//
// Multi-channel direct digital synthesiser. A shared divider produces a
// sample tick every DIV clocks. On each tick every enabled channel advances
// its phase accumulator by its active tuning word. The registered outputs are
// refreshed in the cycle after the tick. Each channel can generate a sawtooth,
// square, triangle, variable-duty pulse or shared-LFSR noise waveform. A mix
// output carries the exact unsigned sum of all channel samples.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   wr_en        register write strobe (one write per asserted cycle)
//   wr_ch        target channel; indices >= CH are ignored
//   wr_addr      0 tuning (shadowed), 1 phase offset, 2 duty, 3 control
//   wr_data      write data; control = {phase_reset[4], enable[3], wave[2:0]}
//   ch_out       registered per-channel samples, channel k at [k*M +: M]
//   mix_out      registered sum of all channel samples
//   sample_valid one-cycle strobe marking new ch_out / mix_out
// -----------------------------------------------------------------------------
module dds_multichannel #(
  parameter int CH   = 4,
  parameter int N    = 14,
  parameter int M    = 12,
  parameter int TUNE = 16,
  parameter int DIV  = 14
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     wr_en,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0]   wr_ch,
  input  logic [1:0]                               wr_addr,
  input  logic [TUNE-1:0]                          wr_data,
  output logic [CH*M-1:0]                          ch_out,
  output logic [M+((CH > 1) ? $clog2(CH) : 1)-1:0] mix_out,
  output logic                                     sample_valid
);

  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int MIXW = M + CHW;
  localparam int CNTW = $clog2(DIV);

  localparam logic [CHW:0]  CH_L       = (CHW+1)'(CH);
  localparam logic [M-1:0]  FS         = '1;
  localparam logic [M-1:0]  DUTY_RESET = {1'b1, {(M-1){1'b0}}};
  localparam logic [22:0]   LFSR_SEED  = 23'd1;

  localparam logic [1:0] ADDR_TUNE   = 2'd0;
  localparam logic [1:0] ADDR_OFFSET = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam logic [2:0] WAVE_SAW    = 3'd0;
  localparam logic [2:0] WAVE_SQUARE = 3'd1;
  localparam logic [2:0] WAVE_TRI    = 3'd2;
  localparam logic [2:0] WAVE_PULSE  = 3'd3;
  localparam logic [2:0] WAVE_NOISE  = 3'd4;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            tick;
  logic            tick_q;
  logic [22:0]     lfsr_q, lfsr_d;

  logic [TUNE-1:0] acc_q    [CH];
  logic [TUNE-1:0] acc_d    [CH];
  logic [TUNE-1:0] shadow_q [CH];
  logic [TUNE-1:0] shadow_d [CH];
  logic [TUNE-1:0] active_q [CH];
  logic [TUNE-1:0] active_d [CH];
  logic [N-1:0]    offset_q [CH];
  logic [N-1:0]    offset_d [CH];
  logic [M-1:0]    duty_q   [CH];
  logic [M-1:0]    duty_d   [CH];
  logic [2:0]      wave_q   [CH];
  logic [2:0]      wave_d   [CH];
  logic            enable_q [CH];
  logic            enable_d [CH];
  logic            pend_q   [CH];
  logic            pend_d   [CH];

  logic [CH*M-1:0] ch_out_q;
  logic [MIXW-1:0] mix_q;
  logic            valid_q;

  // Combinational sample path
  logic [M-1:0]    sample [CH];
  logic [N-1:0]    phase;
  logic [M-1:0]    phase_top;
  logic [N-2:0]    fold;
  logic [M-1:0]    tri_val;
  logic [M-1:0]    wave_val;
  logic [CH*M-1:0] ch_pack;
  logic [MIXW-1:0] mix_sum;
  logic            wr_ok;

  // ---------------------------------------------------------------------------
  // Sample-rate divider and shared noise source
  // ---------------------------------------------------------------------------
  assign tick  = (cnt_q == CNTW'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Fibonacci LFSR, taps 23 and 18; steps once per sample so every noise
  // channel sees the same value within a sample period.
  assign lfsr_d = tick ? {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]} : lfsr_q;

  // Channel indices beyond CH address nothing.
  assign wr_ok = wr_en && ({1'b0, wr_ch} < CH_L);

  // ---------------------------------------------------------------------------
  // Per-channel register file and accumulators
  //
  // Tick handling is evaluated first from the current register values, then
  // any write is layered on top. A write that lands on a tick edge is
  // therefore stored, but the tick itself sees only pre-write state.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      // NOTE: every always_comb output gets a default before any branch so
      // partial assignments can never infer a latch.
      acc_d[k]    = acc_q[k];
      shadow_d[k] = shadow_q[k];
      active_d[k] = active_q[k];
      offset_d[k] = offset_q[k];
      duty_d[k]   = duty_q[k];
      wave_d[k]   = wave_q[k];
      enable_d[k] = enable_q[k];
      pend_d[k]   = pend_q[k];

      if (tick) begin
        // Frequency changes commit on a sample boundary. The accumulator
        // still advances by the tuning word that was active before this edge.
        active_d[k] = shadow_q[k];
        if (pend_q[k]) begin
          // A pending phase reset fires even on a disabled channel.
          acc_d[k]  = '0;
          pend_d[k] = 1'b0;
        end else if (enable_q[k]) begin
          acc_d[k] = acc_q[k] + active_q[k];
        end
      end

      if (wr_ok && (wr_ch == CHW'(k))) begin
        case (wr_addr)
          ADDR_TUNE:   shadow_d[k] = wr_data;
          ADDR_OFFSET: offset_d[k] = wr_data[N-1:0];
          ADDR_DUTY:   duty_d[k]   = wr_data[M-1:0];
          ADDR_CTRL: begin
            wave_d[k]   = wr_data[2:0];
            enable_d[k] = wr_data[3];
            // Only a set request is honoured here; clearing happens on the tick.
            if (wr_data[4]) pend_d[k] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Waveform generation
  // ---------------------------------------------------------------------------
  always_comb begin
    phase     = '0;
    phase_top = '0;
    fold      = '0;
    tri_val   = '0;
    wave_val  = '0;
    for (int k = 0; k < CH; k++) begin
      // Phase is the top N accumulator bits plus the offset, wrapping mod 2^N.
      phase     = N'(acc_q[k] >> (TUNE - N)) + offset_q[k];
      phase_top = M'(phase >> (N - M));
      // The triangle mirrors the lower phase half about the MSB so it
      // rises for the first half cycle and falls for the second.
      fold      = phase[N-1] ? ~phase[N-2:0] : phase[N-2:0];
      tri_val   = M'(fold >> (N - 1 - M));

      case (wave_q[k])
        WAVE_SAW:    wave_val = phase_top;
        WAVE_SQUARE: wave_val = phase[N-1] ? '0 : FS;
        WAVE_TRI:    wave_val = tri_val;
        WAVE_PULSE:  wave_val = (phase_top < duty_q[k]) ? FS : '0;
        WAVE_NOISE:  wave_val = lfsr_q[M-1:0];
        default:     wave_val = '0;
      endcase

      sample[k] = enable_q[k] ? wave_val : '0;
    end
  end

  // Unsigned sum is sized to hold CH full-scale samples without overflow.
  always_comb begin
    mix_sum = '0;
    ch_pack = '0;
    for (int k = 0; k < CH; k++) begin
      mix_sum             = mix_sum + MIXW'(sample[k]);
      ch_pack[k*M +: M]   = sample[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      ch_out_q <= '0;
      mix_q    <= '0;
      valid_q  <= 1'b0;
      // NOTE: the per-channel arrays are reset element by element because
      // their reset values (e.g. mid-scale duty, disabled channel) are
      // visible at the outputs; they are flops, not an inferred RAM.
      for (int k = 0; k < CH; k++) begin
        acc_q[k]    <= '0;
        shadow_q[k] <= '0;
        active_q[k] <= '0;
        offset_q[k] <= '0;
        duty_q[k]   <= DUTY_RESET;
        wave_q[k]   <= WAVE_SAW;
        enable_q[k] <= 1'b0;
        pend_q[k]   <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge value of every other register, independent of statement order.
      cnt_q  <= cnt_d;
      tick_q <= tick;
      lfsr_q <= lfsr_d;
      for (int k = 0; k < CH; k++) begin
        acc_q[k]    <= acc_d[k];
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
        offset_q[k] <= offset_d[k];
        duty_q[k]   <= duty_d[k];
        wave_q[k]   <= wave_d[k];
        enable_q[k] <= enable_d[k];
        pend_q[k]   <= pend_d[k];
      end
      // Outputs are captured in the cycle after the accumulators move and
      // hold until the next sample.
      if (tick_q) begin
        ch_out_q <= ch_pack;
        mix_q    <= mix_sum;
      end
      valid_q <= tick_q;
    end
  end

  assign ch_out       = ch_out_q;
  assign mix_out      = mix_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_dds_multichannel.sv
// -----------------------------------------------------------------------------
// tb_dds_multichannel
//
// Directed bench for dds_multichannel at default parameters
// (CH=4, N=14, M=12, TUNE=16, DIV=14). Inputs are driven and outputs
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dds_multichannel;

  localparam int CH   = 4;
  localparam int N    = 14;
  localparam int M    = 12;
  localparam int TUNE = 16;
  localparam int DIV  = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [1:0]      wr_ch;
  logic [1:0]      wr_addr;
  logic [15:0]     wr_data;
  logic [47:0]     ch_out;
  logic [13:0]     mix_out;
  logic            sample_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dds_multichannel #(
    .CH(CH), .N(N), .M(M), .TUNE(TUNE), .DIV(DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .ch_out       (ch_out),
    .mix_out      (mix_out),
    .sample_valid (sample_valid)
  );

  function automatic logic [11:0] ch_of(input int k);
    return ch_out[k*M +: M];
  endfunction

  // Called on a falling edge; the write is captured at the next rising edge.
  task automatic wr(input int ch, input int addr, input int data);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_addr = 2'(addr);
    wr_data = 16'(data);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance to the next falling edge with sample_valid high (bounded).
  task automatic wait_strobe(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 3*DIV; i++) begin
      @(negedge clk);
      cyc++;
      if (sample_valid) begin
        seen = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!seen) $display("FAIL strobe_timeout: got no sample_valid in %0d cycles, want one", cyc);
    else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int cyc;
    rst   = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    // Square+enable written during reset must be discarded.
    wr(0, 3, 9);
    total_cnt++;
    if (ch_out !== 48'd0) $display("FAIL reset_ch_out: got %h want 0", ch_out); else pass_cnt++;
    total_cnt++;
    if (mix_out !== 14'd0) $display("FAIL reset_mix: got %0d want 0", mix_out); else pass_cnt++;
    total_cnt++;
    if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", sample_valid); else pass_cnt++;
    rst = 1'b0;
    wait_strobe(cyc);
    total_cnt++;
    if (cyc !== 15) $display("FAIL first_strobe_latency: got %0d want 15", cyc); else pass_cnt++;
    total_cnt++;
    if (ch_out !== 48'd0) $display("FAIL write_in_reset_ignored: got %h want 0", ch_out); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (sample_valid !== 1'b0) $display("FAIL valid_one_cycle: got %b want 0", sample_valid); else pass_cnt++;
  endtask

  // ch0 sawtooth, tune 1024: +64 per sample, wrap after 64 samples.
  task automatic test_saw();
    int cyc;
    do_reset();
    wr(0, 0, 1024);
    wr(0, 3, 8);
    for (int i = 0; i <= 64; i++) begin
      wait_strobe(cyc);
      if (i > 0) begin
        total_cnt++;
        if (cyc !== DIV) $display("FAIL saw_period[%0d]: got %0d want %0d", i, cyc, DIV); else pass_cnt++;
      end
      total_cnt++;
      if (ch_of(0) !== 12'((64*i) % 4096))
        $display("FAIL saw_ch0[%0d]: got %0d want %0d", i, ch_of(0), (64*i) % 4096);
      else pass_cnt++;
      total_cnt++;
      if (mix_out !== 14'((64*i) % 4096))
        $display("FAIL saw_mix[%0d]: got %0d want %0d", i, mix_out, (64*i) % 4096);
      else pass_cnt++;
    end
  endtask

  // ch0 pulse, tune 4096, duty 1024: 4 of every 16 samples high.
  task automatic test_pulse();
    int cyc;
    int highs;
    int exp_v;
    highs = 0;
    do_reset();
    wr(0, 0, 4096);
    wr(0, 2, 1024);
    wr(0, 3, 11);
    for (int i = 0; i < 32; i++) begin
      wait_strobe(cyc);
      exp_v = ((i % 16) < 4) ? 4095 : 0;
      if (ch_of(0) == 12'd4095) highs++;
      total_cnt++;
      if (ch_of(0) !== 12'(exp_v)) $display("FAIL pulse[%0d]: got %0d want %0d", i, ch_of(0), exp_v);
      else pass_cnt++;
    end
    total_cnt++;
    if (highs !== 8) $display("FAIL pulse_duty: got %0d highs want 8", highs); else pass_cnt++;
  endtask

  // Two square channels at tune 0, then disable ch1.
  task automatic test_square_mix();
    int cyc;
    do_reset();
    wr(0, 3, 9);
    wr(1, 3, 9);
    wait_strobe(cyc);
    total_cnt++;
    if (ch_of(0) !== 12'd4095) $display("FAIL sq_ch0: got %0d want 4095", ch_of(0)); else pass_cnt++;
    total_cnt++;
    if (ch_of(1) !== 12'd4095) $display("FAIL sq_ch1: got %0d want 4095", ch_of(1)); else pass_cnt++;
    total_cnt++;
    if (mix_out !== 14'd8190) $display("FAIL sq_mix2: got %0d want 8190", mix_out); else pass_cnt++;
    total_cnt++;
    if (ch_out[47:24] !== 24'd0) $display("FAIL sq_idle_ch: got %h want 0", ch_out[47:24]); else pass_cnt++;
    wr(1, 3, 1);
    wait_strobe(cyc);
    total_cnt++;
    if (ch_of(1) !== 12'd0) $display("FAIL sq_ch1_off: got %0d want 0", ch_of(1)); else pass_cnt++;
    total_cnt++;
    if (ch_of(0) !== 12'd4095) $display("FAIL sq_ch0_keep: got %0d want 4095", ch_of(0)); else pass_cnt++;
    total_cnt++;
    if (mix_out !== 14'd4095) $display("FAIL sq_mix1: got %0d want 4095", mix_out); else pass_cnt++;
  endtask

  // Static phase (tune 0) shaped through offset: triangle, square, wave 5, pulse.
  task automatic test_shapes();
    int cyc;
    do_reset();
    wr(0, 1, 4096);
    wr(0, 3, 10);
    wait_strobe(cyc);
    total_cnt++;
    if (ch_of(0) !== 12'd2048) $display("FAIL tri_rise: got %0d want 2048", ch_of(0)); else pass_cnt++;
    wr(0, 1, 12288);
    wait_strobe(cyc);
    total_cnt++;
    if (ch_of(0) !== 12'd2047) $display("FAIL tri_fall: got %0d want 2047", ch_of(0)); else pass_cnt++;
    wr(0, 3, 9);
    wait_strobe(cyc);
    total_cnt++;
    if (ch_of(0) !== 12'd0) $display("FAIL sq_low_half: got %0d want 0", ch_of(0)); else pass_cnt++;
    wr(0, 1, 0);
    wr(0, 3, 13);
    wait_strobe(cyc);
    total_cnt++;
    if (ch_of(0) !== 12'd0) $display("FAIL wave5_zero: got %0d want 0", ch_of(0)); else pass_cnt++;
    // Reset duty is mid-scale, so phase 0 gives a high pulse.
    wr(0, 3, 11);
    wait_strobe(cyc);
    total_cnt++;
    if (ch_of(0) !== 12'd4095) $display("FAIL pulse_reset_duty: got %0d want 4095", ch_of(0)); else pass_cnt++;
  endtask

  // Tuning write landing on a tick edge, then offset + phase-reset control.
  task automatic test_back_to_back();
    int cyc;
    int exp_v [7] = '{0, 64, 128, 192, 320, 2048, 2176};
    do_reset();
    wr(0, 0, 1024);
    wr(0, 3, 8);
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        // From a strobe, the 13th rising edge is the next tick edge.
        repeat (12) @(negedge clk);
        wr(0, 0, 2048);
      end
      if (i == 5) begin
        wr(0, 1, 8192);
        wr(0, 3, 'h18);
      end
      wait_strobe(cyc);
      total_cnt++;
      if (ch_of(0) !== 12'(exp_v[i]))
        $display("FAIL retune[%0d]: got %0d want %0d", i, ch_of(0), exp_v[i]);
      else pass_cnt++;
    end
  endtask

  // Noise from LFSR seed, then a one-cycle reset mid-sweep.
  task automatic test_noise_reset();
    int cyc;
    do_reset();
    wr(2, 3, 12);
    wr(0, 0, 1024);
    wr(0, 3, 8);
    for (int i = 0; i < 3; i++) begin
      wait_strobe(cyc);
      total_cnt++;
      if (ch_of(2) !== 12'(2 << i)) $display("FAIL noise[%0d]: got %0d want %0d", i, ch_of(2), 2 << i);
      else pass_cnt++;
      total_cnt++;
      if (mix_out !== 14'((2 << i) + 64*i))
        $display("FAIL noise_mix[%0d]: got %0d want %0d", i, mix_out, (2 << i) + 64*i);
      else pass_cnt++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (ch_out !== 48'd0) $display("FAIL midrst_ch_out: got %h want 0", ch_out); else pass_cnt++;
    total_cnt++;
    if (mix_out !== 14'd0) $display("FAIL midrst_mix: got %0d want 0", mix_out); else pass_cnt++;
    total_cnt++;
    if (sample_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", sample_valid); else pass_cnt++;
    wait_strobe(cyc);
    total_cnt++;
    if (cyc !== 15) $display("FAIL midrst_latency: got %0d want 15", cyc); else pass_cnt++;
    total_cnt++;
    if (ch_out !== 48'd0) $display("FAIL midrst_enables: got %h want 0", ch_out); else pass_cnt++;
    wr(2, 3, 12);
    for (int i = 0; i < 2; i++) begin
      wait_strobe(cyc);
      total_cnt++;
      if (ch_of(2) !== 12'(4 << i)) $display("FAIL noise_restart[%0d]: got %0d want %0d", i, ch_of(2), 4 << i);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_addr = '0;
    wr_data = '0;
    test_reset();
    test_saw();
    test_pulse();
    test_square_mix();
    test_shapes();
    test_back_to_back();
    test_noise_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded 1 ms, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dds_multichannel.md
DDS_MULTICHANNEL -- requirements
Module: dds_multichannel

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent DDS channels (1..16).
REQ-002 SHALL have parameter N, default 14, truncated phase width used for waveform generation.
REQ-003 SHALL have parameter M, default 12, per-channel output sample width; requires N >= M+1 and M <= 23.
REQ-004 SHALL have parameter TUNE, default 16, accumulator and tuning-word width; requires TUNE >= N and TUNE >= M.
REQ-005 SHALL have parameter DIV, default 14, sample-rate divide ratio from clk (>= 2).
REQ-006 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port wr_en, input, 1, register write strobe, one write per asserted cycle.
REQ-009 SHALL have port wr_ch, input, max(1,clog2(CH)), target channel index.
REQ-010 SHALL have port wr_addr, input, 2, register select: 0 tuning, 1 phase offset, 2 duty, 3 control.
REQ-011 SHALL have port wr_data, input, TUNE, write data.
REQ-012 SHALL have port ch_out, output, CH*M, registered per-channel samples, channel k at bits [k*M +: M].
REQ-013 SHALL have port mix_out, output, M+clog2(CH) (M+1 when CH=1), registered sum of enabled channel samples.
REQ-014 SHALL have port sample_valid, output, 1, one-cycle strobe marking new ch_out/mix_out.

Function
REQ-015 SHALL run a divider counter 0..DIV-1 in clk; tick is true in the cycle the count equals DIV-1, then the count wraps to 0.
REQ-016 Per channel, SHALL hold acc (TUNE bits), tune_shadow, tune_active, offset (N bits), duty (M bits), wave (3 bits), enable (1 bit).
REQ-017 A write to addr 0 SHALL load tune_shadow only; tune_active SHALL take tune_shadow on the tick edge, so a frequency change lands on a sample boundary.
REQ-018 Writes to addr 1/2 SHALL load offset = wr_data[N-1:0] / duty = wr_data[M-1:0] immediately.
REQ-019 Addr 3 write: wave = wr_data[2:0], enable = wr_data[3]; wr_data[4]=1 sets a per-channel phase-reset pending flag.
REQ-020 Writes with wr_ch >= CH SHALL be ignored.
REQ-021 On the tick edge, an enabled channel SHALL update acc <= acc + tune_active (old active value, modulo 2^TUNE); if phase-reset pending, acc <= 0 instead and the flag clears.
REQ-022 A disabled channel SHALL hold acc; its pending phase reset SHALL still apply at the next tick.
REQ-023 A write coinciding with a tick edge SHALL be stored; the tick uses the pre-write register values, and the new value affects the following tick.
REQ-024 Phase p = acc[TUNE-1 -: N] + offset (mod 2^N); pt = p[N-1 -: M]; FS = 2^M-1.
REQ-025 Wave 0 saw = pt; 1 square = p[N-1] ? 0 : FS; 2 triangle = p[N-1] ? ~p[N-2 -: M] : p[N-2 -: M]; 3 pulse = (pt < duty) ? FS : 0; 4 noise = lfsr[M-1:0]; 5..7 = 0.
REQ-026 SHALL hold one 23-bit Fibonacci LFSR (taps 23,18), advanced once per tick; all noise channels share it.
REQ-027 Disabled channel sample SHALL be 0 and contribute 0 to mix_out.
REQ-028 ch_out, mix_out and sample_valid SHALL register on the clk edge immediately after the tick edge (one-cycle latency from acc update); outputs hold between strobes.
REQ-029 mix_out SHALL be the exact unsigned sum of all channel samples, no saturation or scaling.
REQ-030 sample_valid SHALL be high for exactly one cycle every DIV cycles once out of reset.

Reset
REQ-031 While rst=1 at an edge: divider 0, all acc/tune_shadow/tune_active/offset 0, duty 2^(M-1), wave 0, enable 0, pending flags 0, LFSR 1, ch_out 0, mix_out 0, sample_valid 0; writes ignored.
REQ-032 Reset asserted mid-operation SHALL take effect at that edge regardless of divider state; first tick follows DIV cycles after rst deasserts.

Verification
REQ-033 Defaults, ch0 tune=1024, control=0x08 (saw, enabled) -> ch0 saw rises 64 per sample_valid (0,64,...,4032), wraps to 0 after 64 samples; sample_valid period 14 clks.
REQ-034 ch0 pulse, tune=4096, duty=1024 -> 4 of every 16 samples equal 4095, rest 0 (25% duty).
REQ-035 ch0, ch1 square enabled, tune 0 -> ch0=ch1=4095, mix_out=8190; disable ch1 -> ch1=0, mix_out=4095 at next strobe.
REQ-036 Tuning write on a tick cycle, and control write 0x18 mid-run with offset=8192 -> old tune used for that tick, new tune from next; after reset-flag tick saw=2048.
REQ-037 Assert rst for 1 cycle mid-sweep -> all outputs 0 next cycle, enables cleared, noise restarts from LFSR seed 1 sequence.
